lsu_controller: RTL and testbench
=================================

LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 The block SHALL have ports: rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-003 The block SHALL have ports: instruction_wback  in  32  instruction in memory/writeback stage; opcode [6:0], funct3 [14:12], rd [11:7].
REQ-004 The block SHALL have ports: inst_valid  in  1  instruction_wback holds a real instruction, not a bubble.
REQ-005 The block SHALL have ports: addr  in  32  effective address (ALU result); wdata  in  32  store data (rs2 value).
REQ-006 The block SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  32, word-aligned; mem_be  out  4; mem_wdata  out  32.
REQ-007 The block SHALL have ports: mem_gnt  in  1  request accepted; mem_rvalid  in  1  read data valid; mem_rdata  in  32.
REQ-008 The block SHALL have ports: stall  out  1  freeze pipeline; load_data  out  32; load_valid  out  1  register write of load_data; rd_wback  out  5; misaligned  out  1  error pulse.

Function
REQ-009 The block SHALL treat opcode 0000011 as load and 0100011 as store; all other opcodes SHALL be ignored and produce no output activity.
REQ-010 The block SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-011 In IDLE, a valid, legal, aligned load/store SHALL assert stall combinationally in that same cycle, register addr, wdata, funct3 and rd, and move to REQ.
REQ-012 Alignment: a halfword access with addr[0]=1, a word access with addr[1:0]!=0, or funct3 in {011,110,111} (or store funct3 >010) SHALL pulse misaligned for 1 cycle in IDLE, issue no request, keep stall=0, and stay in IDLE.
REQ-013 In REQ, the block SHALL hold mem_req=1 with mem_addr={addr[31:2],2'b00} and mem_we, mem_be, mem_wdata stable until mem_gnt=1.
REQ-014 On mem_gnt=1 in REQ, a store SHALL go to DONE and a load SHALL go to WAIT; mem_req SHALL be 0 in every state except REQ.
REQ-015 In WAIT, on mem_rvalid=1 the block SHALL register the extracted and extended data into load_data and go to DONE.
REQ-016 DONE SHALL last exactly 1 cycle with stall=0 and load_valid=1 (loads only), and SHALL then go to IDLE; inst_valid SHALL be ignored in DONE.
REQ-017 stall SHALL be 1 in REQ and WAIT and 0 in DONE; minimum stall is 2 cycles for a store and 3 cycles for a load when gnt and rvalid are immediate.
REQ-018 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111. Store data SHALL be replicated: byte x4, halfword x2, word unchanged.
REQ-019 Load extraction SHALL select the byte/halfword at addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass through.
REQ-020 load_data and rd_wback SHALL hold their values until the next load completes.
REQ-021 mem_gnt outside REQ and mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE and drive all outputs to 0, including mid-transaction; an in-flight request SHALL be abandoned and not retried.
REQ-023 After rst deasserts, the first edge SHALL evaluate in IDLE; a late mem_rvalid from an abandoned load SHALL be ignored.

Verification
REQ-024 SW, addr 0x104, wdata 0xDEADBEEF, gnt immediate -> mem_addr 0x104, mem_be 1111, mem_we 1, stall high 2 cycles, load_valid stays 0.
REQ-025 SB, addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, mem_be 1000, mem_wdata 0xA5A5A5A5.
REQ-026 LB, addr 0x302, rdata 0x12803456 -> load_data 0xFFFFFF80, load_valid 1 cycle, rd_wback = rd; LBU with the same inputs -> 0x00000080.
REQ-027 LH at addr 0x101 -> misaligned 1 cycle, mem_req never 1, stall 0.
REQ-028 LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> mem_req and mem_addr stable for 4 cycles, stall continuous, load_data = rdata.
REQ-029 rst=0 during WAIT -> all outputs 0 immediately; after release, a stray rvalid produces no load_valid.

Source files
------------

// File: rtl/lsu_controller.sv
// lsu_controller
//   Load/store unit sequencer sitting in the memory/writeback stage. Decodes
//   RV32 load/store instructions, checks alignment, runs a single outstanding
//   request on a req/gnt + rvalid memory port, formats store lanes and
//   extracts/extends load data.
//
// Ports
//   clk, rst (async, active-low)
//   instruction_wback/inst_valid : instruction in the stage + bubble qualifier
//   addr, wdata                  : effective address and store data
//   mem_req/we/addr/be/wdata     : memory request (addr is word-aligned)
//   mem_gnt, mem_rvalid, mem_rdata : memory handshake and read return
//   stall                        : freeze the pipeline while an access is open
//   load_data, load_valid, rd_wback : register writeback of a completed load
//   misaligned                   : one-cycle error pulse for illegal accesses
module lsu_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_wback,
    input  logic        inst_valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic [4:0]  rd_wback,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_store_q, is_store_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  rd_wback_q, rd_wback_d;

    // ---------------------------------------------------------------
    // Decode and legality of the incoming instruction
    // ---------------------------------------------------------------
    logic [6:0] opcode_in;
    logic [2:0] funct3_in;
    logic [4:0] rd_in;
    logic       is_load_in, is_store_in;
    logic       funct3_bad, addr_bad;
    logic       start, accept, reject;
    logic       unused_inst_bits;

    assign opcode_in        = instruction_wback[6:0];
    assign rd_in            = instruction_wback[11:7];
    assign funct3_in        = instruction_wback[14:12];
    assign unused_inst_bits = ^instruction_wback[31:15];
    assign is_load_in       = (opcode_in == OP_LOAD);
    assign is_store_in      = (opcode_in == OP_STORE);

    always_comb begin
        funct3_bad = 1'b0;
        addr_bad   = 1'b0;
        if (is_load_in)
            funct3_bad = (funct3_in == 3'b011) || (funct3_in == 3'b110) || (funct3_in == 3'b111);
        else
            funct3_bad = (funct3_in > 3'b010);
        // funct3[1:0] encodes the access size for every legal load/store
        case (funct3_in[1:0])
            2'b01:   addr_bad = addr[0];
            2'b10:   addr_bad = (addr[1:0] != 2'b00);
            default: addr_bad = 1'b0;
        endcase
    end

    // Only IDLE looks at the stage; REQ/WAIT/DONE ignore inst_valid.
    assign start  = (state_q == IDLE) && inst_valid && (is_load_in || is_store_in);
    assign accept = start && !(funct3_bad || addr_bad);
    assign reject = start &&  (funct3_bad || addr_bad);

    // ---------------------------------------------------------------
    // Store lane formatting and load extraction (from registered request)
    // ---------------------------------------------------------------
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [31:0] ld_ext;

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {addr_q[1], 1'b0};
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {24'b0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'b0, rd_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        is_store_d  = is_store_q;
        load_data_d = load_data_q;
        rd_wback_d  = rd_wback_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = REQ;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    funct3_d   = funct3_in;
                    rd_d       = rd_in;
                    is_store_d = is_store_in;
                end
            end
            REQ: begin
                if (mem_gnt)
                    state_d = is_store_q ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    load_data_d = ld_ext;
                    rd_wback_d  = rd_q;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            is_store_q  <= 1'b0;
            load_data_q <= '0;
            rd_wback_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            is_store_q  <= is_store_d;
            load_data_q <= load_data_d;
            rd_wback_q  <= rd_wback_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs. Request fields are zero outside REQ so the port is quiet
    // between accesses. stall/misaligned depend on the live instruction
    // in IDLE, so they are gated with rst to read 0 during reset.
    // misaligned follows the stage: it is high for as long as an illegal
    // instruction is presented in IDLE (one cycle, since stall stays low).
    // ---------------------------------------------------------------
    logic in_req;
    assign in_req     = (state_q == REQ);

    assign mem_req    = in_req;
    assign mem_we     = in_req && is_store_q;
    assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_be     = in_req ? st_be : 4'b0;
    assign mem_wdata  = (in_req && is_store_q) ? st_wdata : 32'b0;

    assign stall      = rst && (accept || (state_q == REQ) || (state_q == WAIT));
    assign misaligned = rst && reject;
    assign load_valid = (state_q == DONE) && !is_store_q;
    assign load_data  = load_data_q;
    assign rd_wback   = rd_wback_q;

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller
//   Directed test of lsu_controller. A transaction-level model predicts the
//   request fields, load result and per-transaction cycle counts; a per-cycle
//   monitor compares the DUT against it, and literal values pin the model.
module tb_lsu_controller;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction_wback = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic [4:0]  rd_wback;
    logic        misaligned;

    lsu_controller dut (
        .clk(clk), .rst(rst),
        .instruction_wback(instruction_wback), .inst_valid(inst_valid),
        .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .rd_wback(rd_wback), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model expectations for the transaction in flight
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [4:0]  exp_rd;

    // per-transaction observations
    int          c_req, c_stall, c_rise, c_lv, c_mis;
    logic        prev_stall = 1'b0;
    logic [31:0] last_addr, last_wdata, last_ld;
    logic [3:0]  last_be;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // ---------------- model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit m_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
        if (op == OP_LD) begin
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        end else if (f3 > 3'd2) begin
            return 1'b1;
        end
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned ofs = a % 4;
        case (m_size(f3))
            1:       return 4'(32'd1 << ofs);
            2:       return 4'(32'd3 << ofs);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b = {24'b0, wd[7:0]};
        logic [31:0] h = {16'b0, wd[15:0]};
        case (m_size(f3))
            1:       return b * 32'h0101_0101;
            2:       return h * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (a % 4));
        bit sgn = (f3[2] == 1'b0);
        if (m_size(f3) == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (m_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    task automatic mon();
        if (stall) c_stall++;
        if (stall && !prev_stall) c_rise++;
        prev_stall = stall;
        if (mem_req) begin
            c_req++;
            check("mem_addr", mem_addr, exp_addr);
            check("mem_we", mem_we, exp_we);
            if (exp_we) begin
                check("mem_be", mem_be, exp_be);
                check("mem_wdata", mem_wdata, exp_wdata);
            end
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
        end
        if (load_valid) begin
            c_lv++;
            check("load_data", load_data, exp_ld);
            check("rd_wback", rd_wback, exp_rd);
            last_ld = load_data;
        end
        if (misaligned) c_mis++;
    endtask

    task automatic clr();
        c_req = 0; c_stall = 0; c_rise = 0; c_lv = 0; c_mis = 0;
        last_addr = '0; last_be = '0; last_wdata = '0; last_ld = '0;
    endtask

    // Present one instruction (called at posedge+1), run it to completion
    // with gnt after gdly REQ cycles and rvalid after rwait WAIT cycles,
    // then check the cycle counts the model predicts.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input int gdly, input int rwait);
        bit lsu = (op == OP_LD) || (op == OP_ST);
        bit is_ld = (op == OP_LD);
        bit bad = lsu && m_illegal(op, f3, a);
        int n_req = 0;
        int w = 0;
        bit gnt_given = 0;
        bit rv_done = 0;
        bit ended = 0;
        int e_req = 0, e_stall = 0, e_lv = 0, e_mis = 0;

        clr();
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_be    = m_be(f3, a);
        exp_wdata = m_wd(f3, wd);
        exp_we    = !is_ld;
        exp_ld    = m_ld(f3, a, rdata);
        exp_rd    = rd;
        if (lsu && bad) e_mis = 1;
        else if (lsu) begin
            e_req   = gdly + 1;
            e_stall = 1 + e_req + (is_ld ? rwait + 1 : 0);
            e_lv    = is_ld ? 1 : 0;
        end

        instruction_wback = {17'($urandom), f3, rd, op};
        inst_valid = 1'b1;
        addr       = a;
        wdata      = wd;
        mem_rdata  = rdata;

        for (int cyc = 0; cyc < 60 && !ended; cyc++) begin
            @(negedge clk);
            mon();
            if (!stall) ended = 1;
            @(posedge clk); #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (ended) inst_valid = 1'b0;
            else if (mem_req) begin
                if (n_req == gdly) begin mem_gnt = 1'b1; gnt_given = 1; end
                n_req++;
            end else if (gnt_given && is_ld && !rv_done) begin
                if (w == rwait) begin mem_rvalid = 1'b1; rv_done = 1; end
                w++;
            end
        end
        check("completed", ended, 1);
        // one more cycle: nothing must restart after DONE
        @(negedge clk);
        mon();
        @(posedge clk); #1;

        check("req_cycles", c_req, e_req);
        check("stall_cycles", c_stall, e_stall);
        check("stall_runs", c_rise, (e_stall > 0) ? 1 : 0);
        check("load_valid_cycles", c_lv, e_lv);
        check("misaligned_cycles", c_mis, e_mis);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset state, with a legal load presented during reset
        instruction_wback = {17'h0, 3'b010, 5'd3, OP_LD};
        inst_valid = 1'b1;
        #12;
        check("reset_ctrl", {mem_req, mem_we, stall, load_valid, misaligned, mem_be, rd_wback}, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_load_data", load_data, 0);
        #1 rst = 1'b1; inst_valid = 1'b0;
        @(posedge clk); #1;

        // SW 0x104 DEADBEEF, immediate gnt
        run_op(OP_ST, 3'b010, 5'd1, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
        check("sw_addr_lit", last_addr, 32'h104);
        check("sw_be_lit", last_be, 4'b1111);
        check("sw_stall_lit", c_stall, 2);
        check("sw_lv_lit", c_lv, 0);

        // SB 0x203 A5
        run_op(OP_ST, 3'b000, 5'd2, 32'h203, 32'h000000A5, 32'h0, 0, 0);
        check("sb_addr_lit", last_addr, 32'h200);
        check("sb_be_lit", last_be, 4'b1000);
        check("sb_wdata_lit", last_wdata, 32'hA5A5A5A5);

        // LB / LBU at 0x302
        run_op(OP_LD, 3'b000, 5'd5, 32'h302, 32'h0, 32'h12803456, 0, 0);
        check("lb_lit", last_ld, 32'hFFFFFF80);
        check("lb_stall_lit", c_stall, 3);
        run_op(OP_LD, 3'b100, 5'd6, 32'h302, 32'h0, 32'h12803456, 0, 0);
        check("lbu_lit", last_ld, 32'h00000080);

        // LH misaligned
        run_op(OP_LD, 3'b001, 5'd7, 32'h101, 32'h0, 32'h0, 0, 0);
        check("lh_mis_lit", c_mis, 1);
        check("lh_mis_req_lit", c_req, 0);

        // LW, gnt after 3 cycles, rvalid 2 cycles after gnt
        run_op(OP_LD, 3'b010, 5'd8, 32'h40, 32'h0, 32'hCAFEF00D, 3, 1);
        check("lw_req_lit", c_req, 4);
        check("lw_data_lit", last_ld, 32'hCAFEF00D);

        // halfword loads, upper lane
        run_op(OP_LD, 3'b101, 5'd10, 32'h102, 32'h0, 32'h80011234, 0, 0);
        check("lhu_lit", last_ld, 32'h00008001);
        run_op(OP_LD, 3'b001, 5'd11, 32'h102, 32'h0, 32'h80011234, 1, 2);
        check("lh_lit", last_ld, 32'hFFFF8001);

        // SH upper half; load result must survive the store
        run_op(OP_ST, 3'b001, 5'd12, 32'h106, 32'h1234BEEF, 32'h0, 1, 0);
        check("sh_be_lit", last_be, 4'b1100);
        check("sh_wdata_lit", last_wdata, 32'hBEEFBEEF);
        check("hold_load_data", load_data, 32'hFFFF8001);
        check("hold_rd_wback", rd_wback, 5'd11);

        // illegal encodings and a non-memory opcode
        run_op(OP_ST, 3'b010, 5'd13, 32'h102, 32'h1, 32'h0, 0, 0);
        run_op(OP_ST, 3'b011, 5'd14, 32'h100, 32'h1, 32'h0, 0, 0);
        run_op(OP_LD, 3'b110, 5'd15, 32'h100, 32'h0, 32'h0, 0, 0);
        run_op(OP_ALU, 3'b000, 5'd16, 32'h100, 32'h0, 32'h0, 0, 0);
        check("alu_quiet_lit", c_stall + c_req + c_mis, 0);

        // byte lanes 1 and 3, store byte at lane 1
        run_op(OP_LD, 3'b000, 5'd17, 32'h001, 32'h0, 32'hFFFF7F00, 0, 0);
        check("lb_pos_lit", last_ld, 32'h0000007F);
        run_op(OP_LD, 3'b100, 5'd18, 32'h003, 32'h0, 32'hC3000000, 2, 0);
        run_op(OP_ST, 3'b000, 5'd19, 32'h005, 32'h00000077, 32'h0, 0, 0);
        run_op(OP_LD, 3'b010, 5'd31, 32'h80, 32'h0, 32'h0BADF00D, 0, 0);

        // gnt/rvalid while idle must be ignored
        clr();
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mon(); @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("idle_strobes_req", c_req, 0);
        check("idle_strobes_lv", c_lv + c_stall, 0);

        // reset while a load waits for data
        instruction_wback = {17'h0, 3'b010, 5'd9, OP_LD};
        inst_valid = 1'b1;
        addr = 32'h88;
        mem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("wait_stall", stall, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_ctrl", {mem_req, mem_we, stall, load_valid, misaligned, mem_be, rd_wback}, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_load_data", load_data, 0);
        inst_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        clr();
        mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mon(); @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        check("stray_rvalid_lv", c_lv, 0);
        check("stray_rvalid_req", c_req + c_stall, 0);
        check("stray_rvalid_data", load_data, 0);

        // normal operation after reset
        run_op(OP_LD, 3'b010, 5'd20, 32'h200, 32'h0, 32'h13579BDF, 1, 1);
        check("post_rst_lw_lit", last_ld, 32'h13579BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
